// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared state encoding and step-count helper for the iterative multiplier
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Number of BUSY cycles needed to retire every multiplier bit.
  function automatic int step_count(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, signed or unsigned per operation, with valid/ready handshakes
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int Width        = 8,
  parameter int BitsPerCycle = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [Width-1:0]     a_i,
  input  logic [Width-1:0]     b_i,
  input  logic                 signed_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*Width-1:0]   result_o
);

  localparam int Steps = step_count(Width, BitsPerCycle);
  localparam int CntW  = $clog2(Steps + 1);
  localparam int SumW  = Width + BitsPerCycle;

  if (Width < 2 || !(BitsPerCycle == 1 || BitsPerCycle == 2 || BitsPerCycle == 4) ||
      (Width % BitsPerCycle) != 0) begin : g_bad_params
    $error("seq_multiplier: illegal Width/BitsPerCycle combination");
  end

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [Width-1:0]      acc_q, acc_d;
  logic [Width-1:0]      mplr_q, mplr_d;
  logic [Width-1:0]      mag_a_q, mag_a_d;
  logic                  neg_q, neg_d;
  logic [2*Width-1:0]    result_q, result_d;
  logic [SumW-1:0]       addend;
  logic [SumW-1:0]       sum;
  logic [2*Width-1:0]    product;

  // Two's-complement magnitude; the most negative value maps onto its unsigned twin.
  function automatic logic [Width-1:0] magnitude(input logic [Width-1:0] v, input logic s);
    return (s && v[Width-1]) ? -v : v;
  endfunction

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;

  // Partial product of the low multiplier bits, then the {acc, multiplier} shift.
  always_comb begin
    addend  = {{BitsPerCycle{1'b0}}, mag_a_q} * {{Width{1'b0}}, mplr_q[BitsPerCycle-1:0]};
    sum     = {{BitsPerCycle{1'b0}}, acc_q} + addend;
    product = (2*Width)'({sum, mplr_q} >> BitsPerCycle);
  end

  // Next-state logic: capture in IDLE, one step per BUSY cycle, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    mag_a_d  = mag_a_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          state_d = BUSY;
          count_d = '0;
          acc_d   = '0;
          mag_a_d = magnitude(a_i, signed_i);
          mplr_d  = magnitude(b_i, signed_i);
          neg_d   = signed_i && (a_i[Width-1] ^ b_i[Width-1]);
        end
      end
      BUSY: begin
        acc_d   = product[2*Width-1:Width];
        mplr_d  = product[Width-1:0];
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(Steps - 1)) begin
          state_d  = DONE;
          result_d = neg_q ? -product : product;
        end
      end
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that also aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      mag_a_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      mag_a_q  <= mag_a_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: three lanes (1, 2 and 4 bits per cycle) with directed plus random traffic and a scoreboard
module tb_seq_multiplier;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] res;
    int             acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst       [3];
  logic           in_valid  [3];
  logic           in_ready  [3];
  logic [W-1:0]   a         [3];
  logic [W-1:0]   b         [3];
  logic           sgn       [3];
  logic           out_valid [3];
  logic           out_ready [3];
  logic [2*W-1:0] result    [3];
  bit             lane_done [3];

  // Reference product from plain integer arithmetic, reduced modulo 2^(2W).
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int px, py;
    px = s ? int'($signed(x)) : int'(x);
    py = s ? int'($signed(y)) : int'(y);
    return (2*W)'(px * py);
  endfunction

  task automatic check(input int lane, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL lane%0d %s: got %0h expected %0h", lane, name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'h7F;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int BPC   = 1 << k;
    localparam int STEPS = W / BPC;
    localparam int RSTN  = (STEPS - 1 < 3) ? STEPS - 1 : 3;

    exp_t           sb[$];
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [2*W-1:0] prev_res   = '0;
    bit             rnd_ready   = 1'b0;
    bit             force_ready = 1'b1;

    seq_multiplier #(.Width(W), .BitsPerCycle(BPC)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[k]),
      .in_valid_i (in_valid[k]),
      .in_ready_o (in_ready[k]),
      .a_i        (a[k]),
      .b_i        (b[k]),
      .signed_i   (sgn[k]),
      .out_valid_o(out_valid[k]),
      .out_ready_i(out_ready[k]),
      .result_o   (result[k])
    );

    always @(posedge clk) out_ready[k] <= rnd_ready ? ($urandom_range(0, 3) != 0) : force_ready;

    // Monitor: push on accept, pop and compare on output handshake, check latency and hold.
    always @(negedge clk) begin
      if (rst[k] !== 1'b0) begin
        sb.delete();
        prev_valid = 1'b0;
      end else begin
        if (in_valid[k] && in_ready[k]) sb.push_back('{ref_mul(a[k], b[k], sgn[k]), cyc + 1});
        if (out_valid[k]) begin
          check(k, "in_ready_in_done", 32'(in_ready[k]), 0);
          check(k, "sb_nonempty", 32'(sb.size() != 0), 1);
          if (!prev_valid && sb.size() != 0) check(k, "latency", cyc - sb[0].acc_cyc, STEPS);
          if (prev_valid && !prev_ready) check(k, "result_hold", 32'(result[k]), 32'(prev_res));
          if (out_ready[k] && sb.size() != 0) check(k, "sb_result", 32'(result[k]), 32'(sb.pop_front().res));
        end
        prev_valid = out_valid[k];
        prev_ready = out_ready[k];
        prev_res   = result[k];
      end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      bit got = 1'b0;
      in_valid[k] = 1'b1;
      a[k] = x;
      b[k] = y;
      sgn[k] = s;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (in_ready[k]) begin
          got = 1'b1;
          break;
        end
      end
      check(k, "accept_timeout", 32'(got), 1);
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      a[k] = W'($urandom);
      b[k] = W'($urandom);
      sgn[k] = 1'($urandom);
    endtask

    task automatic wait_out(input string name, input logic [2*W-1:0] exp);
      bit got = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (out_valid[k] && out_ready[k]) begin
          got = 1'b1;
          break;
        end
        check(k, "in_ready_while_busy", 32'(in_ready[k]), 0);
      end
      check(k, "output_timeout", 32'(got), 1);
      if (got) check(k, name, 32'(result[k]), 32'(exp));
    endtask

    initial begin
      bit got;
      logic [W-1:0] ox, oy;
      logic [W-1:0] da [6] = '{8'hFF, 8'h80, 8'h80, 8'h00, 8'h03, 8'hA5};
      logic [W-1:0] db [6] = '{8'hFF, 8'h80, 8'h7F, 8'hFB, 8'hFF, 8'h3C};
      logic         ds [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2*W-1:0] dr [6] = '{16'hFE01, 16'h4000, 16'hC080, 16'h0000, 16'hFFFD, 16'h26AC};
      rst[k] = 1'b1;
      in_valid[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
      sgn[k] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(k, "ready_in_reset", 32'(in_ready[k]), 0);
      @(posedge clk);
      #1 rst[k] = 1'b0;
      @(negedge clk);
      check(k, "reset_out_valid", 32'(out_valid[k]), 0);
      check(k, "reset_result", 32'(result[k]), 0);
      check(k, "reset_in_ready", 32'(in_ready[k]), 1);
      for (int i = 0; i < 6; i++) begin
        send(da[i], db[i], ds[i]);
        wait_out($sformatf("directed%0d", i), dr[i]);
      end
      force_ready = 1'b0;
      @(posedge clk);
      #1;
      send(8'h12, 8'h34, 1'b0);
      got = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (out_valid[k]) begin
          got = 1'b1;
          break;
        end
      end
      check(k, "bp_valid_timeout", 32'(got), 1);
      in_valid[k] = 1'b1;
      a[k] = 8'h55;
      b[k] = 8'h66;
      sgn[k] = 1'b0;
      repeat (5) begin
        @(negedge clk);
        check(k, "bp_in_ready", 32'(in_ready[k]), 0);
        check(k, "bp_out_valid", 32'(out_valid[k]), 1);
        check(k, "bp_result", 32'(result[k]), 32'h03A8);
      end
      force_ready = 1'b1;
      @(negedge clk);
      check(k, "bp_release_valid", 32'(out_valid[k]), 1);
      @(negedge clk);
      check(k, "bp_idle_ready", 32'(in_ready[k]), 1);
      check(k, "bp_idle_valid", 32'(out_valid[k]), 0);
      @(posedge clk);
      #1 in_valid[k] = 1'b0;
      wait_out("bp_next_op", 16'h21DE);
      @(posedge clk);
      #1;
      send(8'h77, 8'h99, 1'b1);
      repeat (RSTN) @(posedge clk);
      #1 rst[k] = 1'b1;
      @(posedge clk);
      #1 rst[k] = 1'b0;
      @(negedge clk);
      check(k, "abort_out_valid", 32'(out_valid[k]), 0);
      check(k, "abort_in_ready", 32'(in_ready[k]), 1);
      check(k, "abort_result", 32'(result[k]), 0);
      send(8'd7, 8'd6, 1'b0);
      wait_out("after_abort", 16'h002A);
      rnd_ready = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        ox = pick();
        oy = pick();
        send(ox, oy, 1'($urandom));
      end
      for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
      check(k, "drain", 32'(sb.size()), 0);
      lane_done[k] = 1'b1;
    end
  end

  initial begin
    bit all_done = 1'b0;
    for (int t = 0; t < 90000 && !all_done; t++) begin
      @(posedge clk);
      all_done = lane_done[0] && lane_done[1] && lane_done[2];
    end
    if (!all_done) begin
      tests++;
      fails++;
      $display("FAIL global_timeout: got lanes_done=%0b%0b%0b expected 111", lane_done[2], lane_done[1], lane_done[0]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
